// File: rtl/lot_sensor_decoder.sv
// ----------------------------------------------------------------------------
// lot_sensor_decoder
//
// Front end for the lot occupancy counter. Two raw gate photo-beams (A on the
// street side, B on the lot side) are synchronised, debounced as one 2-bit
// vector and tracked by a crossing FSM. The block emits a one-clock enter or
// exit pulse only for a complete, legal crossing:
//   entry : a,b = 10 -> 11 -> 01 -> 00
//   exit  : a,b = 01 -> 11 -> 10 -> 00
//
// Optional feature (compile-time macro LOT_SENSOR_TIMEOUT_EN):
//   defined   - a watchdog forces the FSM to ERR when a crossing stays in one
//               position for TIMEOUT_CYCLES clocks.
//   undefined - no watchdog; a crossing may stay in progress indefinitely and
//               TIMEOUT_CYCLES has no effect.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable clocks before a pair change is taken (>=1)
//   TIMEOUT_CYCLES  : watchdog limit in clocks (only with LOT_SENSOR_TIMEOUT_EN)
//
// Ports
//   clk      in  system clock, rising edge
//   reset    in  asynchronous, active-high reset
//   sensor_a in  raw street-side beam, 1 = blocked, asynchronous to clk
//   sensor_b in  raw lot-side beam, 1 = blocked, asynchronous to clk
//   enter    out one-clock pulse: car completed entry
//   exit     out one-clock pulse: car completed exit
//   busy     out level: crossing in progress (FSM not IDLE and not ERR)
//   error    out level: FSM is in ERR (illegal sequence or timeout)
// ----------------------------------------------------------------------------
module lot_sensor_decoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic sensor_a,
    input  logic sensor_b,
    output logic enter,
    output logic exit,
    output logic busy,
    output logic error
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        EN_A  = 3'd1,
        EN_AB = 3'd2,
        EN_B  = 3'd3,
        EX_B  = 3'd4,
        EX_AB = 3'd5,
        EX_A  = 3'd6,
        ERR   = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Two-flop synchronisers
    // ------------------------------------------------------------------
    logic a_s1, a_s2, b_s1, b_s2;
    logic [1:0] s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_s1 <= 1'b0;
            a_s2 <= 1'b0;
            b_s1 <= 1'b0;
            b_s2 <= 1'b0;
        end else begin
            a_s1 <= sensor_a;
            a_s2 <= a_s1;
            b_s1 <= sensor_b;
            b_s2 <= b_s1;
        end
    end

    assign s = {a_s2, b_s2};

    // ------------------------------------------------------------------
    // Pair debouncer
    // run_len is the number of consecutive edges, including the current
    // one, at which s has held its present value (saturating). A change of
    // s restarts the run, so any glitch shorter than DEBOUNCE_CYCLES is
    // never accepted. deb_chg marks the edge after deb moved, which is the
    // edge at which the FSM reacts.
    // ------------------------------------------------------------------
    logic [1:0]       s_q;
    logic [1:0]       deb;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] run_len;
    logic             deb_accept;
    logic             deb_chg;

    always_comb begin
        run_len = cnt;
        if (s != s_q) begin
            run_len = CNT_W'(1);
        end else if (cnt != CNT_MAX) begin
            run_len = cnt + 1'b1;
        end
    end

    assign deb_accept = (s != deb) && (run_len == CNT_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_q     <= 2'b00;
            cnt     <= '0;
            deb     <= 2'b00;
            deb_chg <= 1'b0;
        end else begin
            s_q     <= s;
            cnt     <= run_len;
            deb_chg <= deb_accept;
            if (deb_accept) begin
                deb <= s;
            end
        end
    end

    // ------------------------------------------------------------------
    // Crossing FSM
    // ------------------------------------------------------------------
    state_t state, state_next;
    logic   timeout_hit;
    logic   enter_d, exit_d, busy_d, error_d;

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            enter <= 1'b0;
            exit  <= 1'b0;
            busy  <= 1'b0;
            error <= 1'b0;
        end else begin
            state <= state_next;
            enter <= enter_d;
            exit  <= exit_d;
            busy  <= busy_d;
            error <= error_d;
        end
    end

    // Next state: moves only on an accepted deb change, or on watchdog expiry
    always_comb begin
        state_next = state;
        if (timeout_hit) begin
            state_next = ERR;
        end else if (deb_chg) begin
            case (state)
                IDLE: case (deb)
                    2'b10:   state_next = EN_A;
                    2'b01:   state_next = EX_B;
                    2'b11:   state_next = ERR;
                    default: state_next = state;
                endcase
                EN_A: case (deb)
                    2'b11:   state_next = EN_AB;
                    2'b00:   state_next = IDLE;   // car backed out
                    2'b01:   state_next = ERR;
                    default: state_next = state;
                endcase
                EN_AB: case (deb)
                    2'b01:   state_next = EN_B;
                    2'b10:   state_next = EN_A;
                    2'b00:   state_next = ERR;
                    default: state_next = state;
                endcase
                EN_B: case (deb)
                    2'b00:   state_next = IDLE;   // entry complete
                    2'b11:   state_next = EN_AB;
                    2'b10:   state_next = ERR;
                    default: state_next = state;
                endcase
                EX_B: case (deb)
                    2'b11:   state_next = EX_AB;
                    2'b00:   state_next = IDLE;   // car backed out
                    2'b10:   state_next = ERR;
                    default: state_next = state;
                endcase
                EX_AB: case (deb)
                    2'b10:   state_next = EX_A;
                    2'b01:   state_next = EX_B;
                    2'b00:   state_next = ERR;
                    default: state_next = state;
                endcase
                EX_A: case (deb)
                    2'b00:   state_next = IDLE;   // exit complete
                    2'b11:   state_next = EX_AB;
                    2'b01:   state_next = ERR;
                    default: state_next = state;
                endcase
                ERR: case (deb)
                    2'b00:   state_next = IDLE;
                    default: state_next = state;
                endcase
                default: state_next = ERR;
            endcase
        end
    end

    // Output decode of the next state. The only ways into IDLE from EN_B and
    // EX_A are the completing 00, so those transitions are the pulses.
    always_comb begin
        enter_d = (state == EN_B) && (state_next == IDLE);
        exit_d  = (state == EX_A) && (state_next == IDLE);
        busy_d  = (state_next != IDLE) && (state_next != ERR);
        error_d = (state_next == ERR);
    end

    // ------------------------------------------------------------------
    // Crossing watchdog
    // ------------------------------------------------------------------
`ifdef LOT_SENSOR_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    // wd holds the clocks already spent in the current position; the edge
    // on which it would reach TIMEOUT_CYCLES is the edge that enters ERR.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd;
    logic            in_progress;

    assign in_progress = (state != IDLE) && (state != ERR);
    assign timeout_hit = in_progress && (wd == WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd <= '0;
        end else if (!in_progress || (state_next != state)) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end
`else
    // No watchdog: never true, TIMEOUT_CYCLES has no effect in this build.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_lot_sensor_decoder.sv
`timescale 1ns/1ps
module tb_lot_sensor_decoder;

    localparam int DEB = 4;
    localparam int TMO = 50;

    localparam int M_IDLE  = 0;
    localparam int M_ENTER = 1;
    localparam int M_EXIT  = 2;
    localparam int M_ERR   = 3;

    // ------------------------------------------------------------------
    // Clock / reset / DUT
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic reset;
    logic sensor_a, sensor_b;
    logic enter, exit, busy, error;

    always #5 clk = ~clk;

    lot_sensor_decoder #(
        .DEBOUNCE_CYCLES(DEB),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .sensor_a(sensor_a),
        .sensor_b(sensor_b),
        .enter   (enter),
        .exit    (exit),
        .busy    (busy),
        .error   (error)
    );

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a crossing is a walk along the entry sequence
    // 10,11,01,00 (exit = same walk with the beams swapped). One step
    // forward or back is legal; reaching 00 from the last position is a
    // completed crossing, anything else is an error. A pair is accepted
    // once the synchronised samples of the last DEB edges all agree.
    // ------------------------------------------------------------------
    logic [1:0] hist [0:DEB+1];   // hist[0] = raw pair sampled this edge
    logic [1:0] m_deb;
    logic       m_chg;
    int         m_mode, m_pos, m_age;
    logic       m_enter, m_exit;
    logic [3:0] exp_q[$];
    logic [3:0] exp_now;
    int         enter_seen = 0;
    int         exit_seen  = 0;

    function automatic logic [1:0] seq_val(input int mode, input int idx);
        logic [1:0] e;
        case (idx)
            0:       e = 2'b10;
            1:       e = 2'b11;
            2:       e = 2'b01;
            default: e = 2'b00;
        endcase
        return (mode == M_EXIT) ? {e[0], e[1]} : e;
    endfunction

    task automatic model_reset();
        for (int i = 0; i <= DEB + 1; i++) hist[i] = 2'b00;
        m_deb = 2'b00; m_chg = 1'b0;
        m_mode = M_IDLE; m_pos = 0; m_age = 0;
        m_enter = 1'b0; m_exit = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_apply(input logic [1:0] v);
        if (m_mode == M_IDLE) begin
            if (v == seq_val(M_ENTER, 0))     begin m_mode = M_ENTER; m_pos = 0; end
            else if (v == seq_val(M_EXIT, 0)) begin m_mode = M_EXIT;  m_pos = 0; end
            else if (v != 2'b00)              m_mode = M_ERR;
        end else if (m_mode == M_ERR) begin
            if (v == 2'b00) m_mode = M_IDLE;
        end else begin
            if (m_pos < 2 && v == seq_val(m_mode, m_pos + 1)) m_pos++;
            else if (m_pos == 2 && v == 2'b00) begin
                if (m_mode == M_ENTER) m_enter = 1'b1; else m_exit = 1'b1;
                m_mode = M_IDLE;
            end
            else if (m_pos > 0 && v == seq_val(m_mode, m_pos - 1)) m_pos--;
            else if (m_pos == 0 && v == 2'b00) m_mode = M_IDLE;
            else m_mode = M_ERR;
        end
    endtask

    task automatic model_step();
        int   old_mode, old_pos;
        logic timed_out, all_same, in_prog;
        old_mode  = m_mode;
        old_pos   = m_pos;
        timed_out = 1'b0;
        m_enter   = 1'b0;
        m_exit    = 1'b0;
        in_prog   = (m_mode == M_ENTER) || (m_mode == M_EXIT);
`ifdef LOT_SENSOR_TIMEOUT_EN
        // this edge would be the TMO-th spent in the same position
        if (in_prog && (m_age + 1 == TMO)) begin
            m_mode = M_ERR;
            timed_out = 1'b1;
        end
`endif
        if (!timed_out && m_chg) model_apply(m_deb);
        if (!in_prog || m_mode != old_mode || m_pos != old_pos) m_age = 0;
        else m_age++;
        // debounce on the synchronised view (raw delayed by two edges)
        for (int i = DEB + 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = {sensor_a, sensor_b};
        all_same = 1'b1;
        for (int i = 3; i <= DEB + 1; i++) if (hist[i] != hist[2]) all_same = 1'b0;
        m_chg = all_same && (hist[2] != m_deb);
        if (m_chg) m_deb = hist[2];
        exp_q.push_back({m_enter, m_exit,
                         (m_mode == M_ENTER) || (m_mode == M_EXIT),
                         (m_mode == M_ERR)});
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) model_reset();
        else       model_step();
    end

    // Scoreboard: compare every cycle on the falling edge
    always @(negedge clk) begin
        if (!reset && exp_q.size() > 0) begin
            exp_now = exp_q.pop_front();
            check_eq("enter", enter, exp_now[3]);
            check_eq("exit",  exit,  exp_now[2]);
            check_eq("busy",  busy,  exp_now[1]);
            check_eq("error", error, exp_now[0]);
            if (enter) enter_seen++;
            if (exit)  exit_seen++;
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic hold(input logic [1:0] ab, input int n);
        @(negedge clk);
        {sensor_a, sensor_b} = ab;
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic clear_counts();
        #1;
        enter_seen = 0;
        exit_seen  = 0;
    endtask

    task automatic crossing(input logic [1:0] p0, input logic [1:0] p1, input logic [1:0] p2);
        hold(p0, 10); hold(p1, 10); hold(p2, 10); hold(2'b00, 12);
    endtask

    function automatic logic [1:0] gray(input int i);
        case (i)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // Bound on total run time
    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish got=timeout exp=finish");
        $fatal(1, "bench timeout");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    int gi;

    initial begin
        reset = 1'b1;
        sensor_a = 1'b0;
        sensor_b = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_enter", enter, 0);
        check_eq("rst_exit",  exit,  0);
        check_eq("rst_busy",  busy,  0);
        check_eq("rst_error", error, 0);
        #1 reset = 1'b0;
        hold(2'b00, 8);

        // 1: legal entry with exact pulse timing
        clear_counts();
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
        #1 check_eq("t1_busy", busy, 1);
        @(negedge clk);
        {sensor_a, sensor_b} = 2'b00;
        repeat (6) @(posedge clk);
        #1 check_eq("t1_enter_edge6", enter, 0);
        @(posedge clk);
        #1 check_eq("t1_enter_edge7", enter, 1);
        check_eq("t1_exit_edge7", exit, 0);
        hold(2'b00, 10);
        #1 check_eq("t1_enter_count", enter_seen, 1);
        check_eq("t1_exit_count", exit_seen, 0);

        // 2: legal exit
        clear_counts();
        crossing(2'b01, 2'b11, 2'b10);
        #1 check_eq("t2_exit_count", exit_seen, 1);
        check_eq("t2_enter_count", enter_seen, 0);
        check_eq("t2_error", error, 0);

        // 3: glitches on 10, then reversal back out
        clear_counts();
        hold(2'b10, 8); hold(2'b00, 2); hold(2'b10, 6); hold(2'b00, 2); hold(2'b10, 8);
        #1 check_eq("t3_busy_after_glitch", busy, 1);
        hold(2'b11, 10); hold(2'b10, 10);
        #1 check_eq("t3_busy_back_en_a", busy, 1);
        hold(2'b00, 10);
        #1 check_eq("t3_busy_idle", busy, 0);
        check_eq("t3_pulses", enter_seen + exit_seen, 0);

        // 4: illegal 10 -> 01, recovery, then a legal entry
        clear_counts();
        hold(2'b10, 10); hold(2'b01, 10);
        #1 check_eq("t4_error", error, 1);
        check_eq("t4_busy", busy, 0);
        hold(2'b00, 10);
        #1 check_eq("t4_error_clear", error, 0);
        check_eq("t4_no_pulse", enter_seen + exit_seen, 0);
        crossing(2'b10, 2'b11, 2'b01);
        #1 check_eq("t4_enter_after", enter_seen, 1);

        // 5: reset while in EN_B
        clear_counts();
        hold(2'b10, 10); hold(2'b11, 10); hold(2'b01, 10);
        #1 check_eq("t5_busy_before", busy, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_eq("t5_async_busy", busy, 0);
        check_eq("t5_async_enter", enter, 0);
        check_eq("t5_async_exit", exit, 0);
        check_eq("t5_async_error", error, 0);
        {sensor_a, sensor_b} = 2'b00;
        repeat (2) @(negedge clk);
        #2 reset = 1'b0;
        hold(2'b00, 15);
        #1 check_eq("t5_no_enter", enter_seen, 0);
        check_eq("t5_idle", busy, 0);

        // 7: reset with both beams blocked
        @(negedge clk);
        #2 reset = 1'b1;
        {sensor_a, sensor_b} = 2'b11;
        @(negedge clk);
        #2 reset = 1'b0;
        hold(2'b11, 12);
        #1 check_eq("t7_error_blocked", error, 1);
        hold(2'b00, 10);
        #1 check_eq("t7_error_clear", error, 0);

        // 6: crossing stalled in EN_A
        @(negedge clk);
        {sensor_a, sensor_b} = 2'b10;
        repeat (56) @(posedge clk);
        #1 check_eq("t6_error_edge56", error, 0);
        check_eq("t6_busy_edge56", busy, 1);
        @(posedge clk);
`ifdef LOT_SENSOR_TIMEOUT_EN
        #1 check_eq("t6_error_edge57", error, 1);
        check_eq("t6_busy_edge57", busy, 0);
`else
        #1 check_eq("t6_error_edge57", error, 0);
        check_eq("t6_busy_edge57", busy, 1);
`endif
        hold(2'b10, 5);
        hold(2'b00, 12);

        // Randomised walk, mostly gray-code neighbours with random holds
        gi = 0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 9) < 7) gi = (gi + ($urandom_range(0, 1) ? 1 : 3)) % 4;
            else                          gi = $urandom_range(0, 3);
            hold(gray(gi), $urandom_range(1, 9));
        end
        hold(2'b00, 15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
